// File: rtl/narrow17_16.sv
// Rounding 17->16 bit narrowing stage (round half up, saturating) feeding a DEPTH-entry output FIFO.
// Optional macro NARROW_SATCNT_EN adds a saturating sat_count port counting saturated pushes.
module narrow17_16 #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [16:0]                in_data,
    input  logic [1:0]                 in_shift,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_data,
    output logic                       out_sat,
    output logic [$clog2(DEPTH):0]     fifo_count
`ifdef NARROW_SATCNT_EN
    ,
    output logic [15:0]                sat_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [17:0]   round_add;
    logic [17:0]   sum;
    logic [17:0]   q;
    logic          sat;
    logic [15:0]   narrowed;

    logic [16:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;

    // Add half an output LSB before shifting so the truncation rounds half up.
    always_comb begin
        round_add = '0;
        if (in_shift != 2'd0) begin
            round_add = 18'd1 << (in_shift - 2'd1);
        end
        sum      = {1'b0, in_data} + round_add;
        q        = sum >> in_shift;
        sat      = |q[17:16];
        narrowed = sat ? 16'hFFFF : q[15:0];
    end

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != '0);
    assign fifo_count = count;

    // Gating with out_valid keeps the head at zero while empty or in reset.
    assign out_data = out_valid ? mem[rd_ptr][15:0] : 16'h0000;
    assign out_sat  = out_valid ? mem[rd_ptr][16]   : 1'b0;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count    <= count_next;
            in_ready <= (count_next < DEPTH_C);
        end
    end

    // NOTE: storage has no reset; contents are only visible through count, which is reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {sat, narrowed};
    end

`ifdef NARROW_SATCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (push && sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_narrow17_16.sv
// Scoreboard bench for narrow17_16: driver queues expected beats on acceptance, monitor checks the FIFO head.
module tb_narrow17_16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [16:0] in_data = '0;
    logic [1:0]  in_shift = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_sat;
    logic [2:0]  fifo_count;
`ifdef NARROW_SATCNT_EN
    logic [15:0] sat_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];  // {sat, data}

    narrow17_16 #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shift(in_shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .fifo_count(fifo_count)
`ifdef NARROW_SATCNT_EN
        , .sat_count(sat_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: the head must always match the oldest expected beat; pop it when consumed.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got 0x%0h with nothing expected at %0t", {out_sat, out_data}, $time);
            end else begin
                check("head_beat", {15'd0, out_sat, out_data}, {15'd0, exp_q[0]});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Waits (bounded) until the beat currently on in_data is accepted, then queues its expectation.
    task automatic wait_accept(input logic [15:0] exp_data, input logic exp_sat);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stayed 0, expected 1 at %0t", $time);
                return;
            end
        end
        exp_q.push_back({exp_sat, exp_data});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [16:0] d, input logic [1:0] s,
                        input logic [15:0] exp_data, input logic exp_sat);
        in_data  = d;
        in_shift = s;
        in_valid = 1'b1;
        wait_accept(exp_data, exp_sat);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_done", exp_q.size(), 0);
        #1;
    endtask

    initial begin
        // Reset state while rst_n is low
        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_fifo_count", fifo_count, 0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_release", in_ready, 1);

        // Single beat, latency into empty FIFO
        in_data = 17'h0ABCD; in_shift = 2'd0; in_valid = 1'b1;
        @(negedge clk);
        check("pre_push_out_valid", out_valid, 0);
        exp_q.push_back({1'b0, 16'hABCD});
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("post_push_out_valid", out_valid, 1);
        check("post_push_count", fifo_count, 1);
        wait_empty();

        // Rounding and saturation vectors
        send(17'h00003, 2'd1, 16'h0002, 1'b0);
        send(17'h1FFFE, 2'd2, 16'h8000, 1'b0);
        send(17'h1FFFF, 2'd0, 16'hFFFF, 1'b1);
        send(17'h1FFFF, 2'd1, 16'hFFFF, 1'b1);
        send(17'h00005, 2'd3, 16'h0001, 1'b0);
        wait_empty();
`ifdef NARROW_SATCNT_EN
        check("sat_count_two", sat_count, 2);
`endif

        // Fill to full with downstream stalled, fifth beat held upstream
        out_ready = 1'b0;
        send(17'h00011, 2'd0, 16'h0011, 1'b0);
        send(17'h00022, 2'd0, 16'h0022, 1'b0);
        send(17'h00033, 2'd0, 16'h0033, 1'b0);
        send(17'h00044, 2'd0, 16'h0044, 1'b0);
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        check("full_count", fifo_count, 4);
        in_data = 17'h00055; in_shift = 2'd0; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("held_in_ready", in_ready, 0);
        check("held_count", fifo_count, 4);
        check("held_head", out_data, 16'h0011);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept(16'h0055, 1'b0);
        wait_empty();

        // Steady push+pop at occupancy 2; 20 beats wraps the pointers several times
        out_ready = 1'b0;
        send(17'h00100, 2'd0, 16'h0100, 1'b0);
        send(17'h00101, 2'd0, 16'h0101, 1'b0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data  = 17'h00102 + 17'(i);
            in_shift = 2'd0;
            @(negedge clk);
            check("stream_count", fifo_count, 2);
            if (in_ready) exp_q.push_back({1'b0, 16'h0102 + 16'(i)});
            else check("stream_in_ready", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_empty();

        // Asynchronous reset with three beats held
        out_ready = 1'b0;
        send(17'h00AAA, 2'd0, 16'h0AAA, 1'b0);
        send(17'h00BBB, 2'd0, 16'h0BBB, 1'b0);
        send(17'h00CCC, 2'd0, 16'h0CCC, 1'b0);
        check("pre_reset_count", fifo_count, 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_count", fifo_count, 0);
        check("async_rst_in_ready", in_ready, 0);
        exp_q.delete();
        #12 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);

        // Normal operation after reset
        send(17'h12345, 2'd3, 16'h2469, 1'b0);
        wait_empty();
`ifdef NARROW_SATCNT_EN
        check("sat_count_cleared", sat_count, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
